md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_ctrl.sv | 140 ++++++++++++++
 tb/tb_md_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_ctrl.sv
// Multiply/divide controller: holds the architectural HI/LO registers and
// times multi-cycle operations. Define MD_DIV_EN to build in the divider.
module md_ctrl #(
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hi_we,
   input  logic        lo_we,
   input  logic [31:0] wdata,
   input  logic        md_use_D,
   output logic        busy,
   output logic        stall_md,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

   state_t      state, state_d;
   logic [3:0]  cnt, cnt_d;
   logic [31:0] hi_d, lo_d;
   logic [31:0] hi_nxt, lo_nxt, hi_nxt_d, lo_nxt_d;
   logic [63:0] res;
   logic        accept;

   // Full 64-bit product; operands are sign- or zero-extended first so a
   // single unsigned multiply serves both mult and multu.
   function automatic logic [63:0] mul_res(input logic uns, input logic [31:0] x,
                                           input logic [31:0] y);
      logic [63:0] xe, ye;
      xe = uns ? {32'd0, x} : {{32{x[31]}}, x};
      ye = uns ? {32'd0, y} : {{32{y[31]}}, y};
      return xe * ye;
   endfunction

`ifdef MD_DIV_EN
   // Sign-magnitude divide: magnitudes are divided unsigned, so the
   // 0x80000000 / -1 case needs no special handling. Divide by zero returns
   // the current {hi, lo} so the commit leaves them unchanged.
   function automatic logic [63:0] div_res(input logic uns, input logic [31:0] x,
                                           input logic [31:0] y, input logic [63:0] keep);
      logic        neg_q, neg_r;
      logic [31:0] ux, uy, q, r;
      logic [63:0] out;
      neg_r = ~uns & x[31];
      neg_q = ~uns & (x[31] ^ y[31]);
      ux    = neg_r ? (32'd0 - x) : x;
      uy    = (~uns & y[31]) ? (32'd0 - y) : y;
      if (y == 32'd0) begin
         out = keep;
      end else begin
         q   = ux / uy;
         r   = ux % uy;
         q   = neg_q ? (32'd0 - q) : q;
         r   = neg_r ? (32'd0 - r) : r;
         out = {r, q};
      end
      return out;
   endfunction

   assign accept = start;
`else
   assign accept = start & ~op[1];
`endif

   always_comb begin
      res = mul_res(op[0], a, b);
`ifdef MD_DIV_EN
      if (op[1]) begin
         res = div_res(op[0], a, b, {hi, lo});
      end
`endif
   end

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      hi_d     = hi;
      lo_d     = lo;
      hi_nxt_d = hi_nxt;
      lo_nxt_d = lo_nxt;
      case (state)
         IDLE: begin
            if (accept) begin
               hi_nxt_d = res[63:32];
               lo_nxt_d = res[31:0];
               cnt_d    = op[1] ? DIV_LOAD : MULT_LOAD;
               state_d  = BUSY;
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         BUSY: begin
            // start and mt* writes are deliberately ignored here
            cnt_d = cnt - 4'd1;
            if (cnt == 4'd1) begin
               hi_d    = hi_nxt;
               lo_d    = lo_nxt;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         hi     <= 32'd0;
         lo     <= 32'd0;
         hi_nxt <= 32'd0;
         lo_nxt <= 32'd0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         hi     <= hi_d;
         lo     <= lo_d;
         hi_nxt <= hi_nxt_d;
         lo_nxt <= lo_nxt_d;
      end
   end

   assign busy     = (state == BUSY);
   assign stall_md = md_use_D & (busy | start);

endmodule

// File: tb/tb_md_ctrl.sv
// Bench for md_ctrl: an abstract cycle model (remaining-busy count plus
// pending result) checked every cycle, plus literal expectations.
module tb_md_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;
`ifdef MD_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b00;
   logic [31:0] a = 32'd0, b = 32'd0;
   logic        hi_we = 1'b0, lo_we = 1'b0;
   logic [31:0] wdata = 32'd0;
   logic        md_use_D = 1'b0;
   logic        busy, stall_md;
   logic [31:0] hi, lo;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   int          m_rem = 0;
   logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
   logic [63:0] m_pend = 64'd0;

   md_ctrl #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .md_use_D(md_use_D),
      .busy(busy), .stall_md(stall_md), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_res(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] ch,
                                             input logic [31:0] cl);
      longint          sx, sy, q, r;
      longint unsigned ux, uy, uq, ur;
      logic [63:0]     out;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      out = 64'd0;
      case (o)
         2'b00: out = 64'(sx * sy);
         2'b01: out = ux * uy;
         2'b10: begin
            if (y == 32'd0) out = {ch, cl};
            else begin
               q = sx / sy;
               r = sx % sy;
               out = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (y == 32'd0) out = {ch, cl};
            else begin
               uq = ux / uy;
               ur = ux % uy;
               out = {ur[31:0], uq[31:0]};
            end
         end
      endcase
      return out;
   endfunction

   // Model: m_rem counts busy cycles left; the pending result lands when it runs out.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_rem  <= 0;
         m_hi   <= 32'd0;
         m_lo   <= 32'd0;
         m_pend <= 64'd0;
      end else if (m_rem > 0) begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_hi <= m_pend[63:32];
            m_lo <= m_pend[31:0];
         end
      end else if (start && (DIV_EN || !op[1])) begin
         m_pend <= model_res(op, a, b, m_hi, m_lo);
         m_rem  <= op[1] ? DC : MC;
      end else begin
         if (hi_we) m_hi <= wdata;
         if (lo_we) m_lo <= wdata;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {63'd0, busy}, {63'd0, (m_rem > 0)});
         chk("stall_md", {63'd0, stall_md}, {63'd0, md_use_D & ((m_rem > 0) | start)});
         chk("hi", {32'd0, hi}, {32'd0, m_hi});
         chk("lo", {32'd0, lo}, {32'd0, m_lo});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int n);
      start = 1'b1;
      op = o;
      a = x;
      b = y;
      tick();
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tick();
      tick();
      chk("reset_busy", {63'd0, busy}, 64'd0);
      chk("reset_hi", {32'd0, hi}, 64'd0);
      chk("reset_lo", {32'd0, lo}, 64'd0);
      chk_en = 1'b1;
      reset = 1'b1;
      tick();

      // mthi + mtlo together, then mthi alone
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hAAAA5555;
      tick();
      lo_we = 1'b0; wdata = 32'h11111111;
      tick();
      hi_we = 1'b0;
      chk("mt_hi", {32'd0, hi}, 64'h11111111);
      chk("mt_lo", {32'd0, lo}, 64'hAAAA5555);

      // signed and unsigned multiply
      do_op(2'b00, 32'hFFFFFFFE, 32'd3, n);
      chk("mult_cycles", 64'(n), 64'(MC));
      chk("mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
      chk("mult_lo", {32'd0, lo}, 64'hFFFFFFFA);
      do_op(2'b01, 32'hFFFFFFFF, 32'd2, n);
      chk("multu_cycles", 64'(n), 64'(MC));
      chk("multu_hi", {32'd0, hi}, 64'h00000001);
      chk("multu_lo", {32'd0, lo}, 64'hFFFFFFFE);

      // start with mthi/mtlo in the same cycle, held through busy
      hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEADBEEF;
      do_op(2'b00, 32'd2, 32'd3, n);
      hi_we = 1'b0; lo_we = 1'b0;
      chk("prio_hi", {32'd0, hi}, 64'd0);
      chk("prio_lo", {32'd0, lo}, 64'd6);

      // stall with md_use_D held; start and mthi during busy are ignored
      md_use_D = 1'b1;
      start = 1'b1; op = 2'b00; a = 32'hFFFFFFFF; b = 32'd5;
      #1;
      chk("stall_start", {63'd0, stall_md}, 64'd1);
      tick();
      a = 32'd9; b = 32'd9; hi_we = 1'b1; wdata = 32'h00001234;
      for (int i = 0; i < MC; i++) begin
         chk("stall_busy", {63'd0, stall_md}, 64'd1);
         tick();
      end
      start = 1'b0; hi_we = 1'b0;
      #1;
      chk("stall_idle", {63'd0, stall_md}, 64'd0);
      chk("busy_idle", {63'd0, busy}, 64'd0);
      chk("mthi_busy_hi", {32'd0, hi}, 64'hFFFFFFFF);
      chk("mthi_busy_lo", {32'd0, lo}, 64'hFFFFFFFB);
      md_use_D = 1'b0;
      tick();

      // back-to-back multiplies
      do_op(2'b00, 32'h80000000, 32'h80000000, n);
      chk("b2b_hi", {32'd0, hi}, 64'h40000000);
      chk("b2b_lo", {32'd0, lo}, 64'd0);
      do_op(2'b01, 32'h12345678, 32'h9ABCDEF0, n);
      do_op(2'b00, 32'h00010000, 32'h00010000, n);
      chk("b2b3_hi", {32'd0, hi}, 64'd1);
      chk("b2b3_lo", {32'd0, lo}, 64'd0);

`ifdef MD_DIV_EN
      // divide by zero straight after commit keeps the committed values
      do_op(2'b11, 32'd5, 32'd0, n);
      chk("div0_cycles", 64'(n), 64'(DC));
      chk("div0_hi", {32'd0, hi}, 64'd1);
      chk("div0_lo", {32'd0, lo}, 64'd0);
      do_op(2'b10, 32'hFFFFFFF9, 32'd2, n);
      chk("div_cycles", 64'(n), 64'(DC));
      chk("div_lo", {32'd0, lo}, 64'hFFFFFFFD);
      chk("div_hi", {32'd0, hi}, 64'hFFFFFFFF);
      do_op(2'b10, 32'd7, 32'hFFFFFFFE, n);
      chk("divneg_lo", {32'd0, lo}, 64'hFFFFFFFD);
      chk("divneg_hi", {32'd0, hi}, 64'd1);
      do_op(2'b11, 32'd100, 32'd7, n);
      chk("divu_lo", {32'd0, lo}, 64'd14);
      chk("divu_hi", {32'd0, hi}, 64'd2);
      do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, n);
      chk("ovf_lo", {32'd0, lo}, 64'h80000000);
      chk("ovf_hi", {32'd0, hi}, 64'd0);
      do_op(2'b01, 32'hFFFFFFFF, 32'd2, n);
`else
      // divide opcodes are ignored without the divider
      do_op(2'b10, 32'hFFFFFFF9, 32'd2, n);
      chk("nodiv_cycles", 64'(n), 64'd0);
      chk("nodiv_hi", {32'd0, hi}, 64'd1);
      chk("nodiv_lo", {32'd0, lo}, 64'd0);
      do_op(2'b11, 32'd100, 32'd7, n);
      chk("nodivu_cycles", 64'(n), 64'd0);
      do_op(2'b01, 32'hFFFFFFFF, 32'd2, n);
`endif

      // reset in busy cycle 3 aborts with no commit
      start = 1'b1; op = DIV_EN ? 2'b10 : 2'b00; a = 32'd77; b = 32'd5;
      tick();
      start = 1'b0;
      tick();
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      tick();
      reset = 1'b1;
      do_op(2'b00, 32'd2, 32'd3, n);
      chk("post_rst_cycles", 64'(n), 64'(MC));
      chk("post_rst_lo", {32'd0, lo}, 64'd6);

      // rerun the basic multiplies
      do_op(2'b00, 32'hFFFFFFFE, 32'd3, n);
      chk("rerun_mult_cycles", 64'(n), 64'(MC));
      chk("rerun_mult_hi", {32'd0, hi}, 64'hFFFFFFFF);
      chk("rerun_mult_lo", {32'd0, lo}, 64'hFFFFFFFA);
      do_op(2'b01, 32'hFFFFFFFF, 32'd2, n);
      chk("rerun_multu_hi", {32'd0, hi}, 64'h00000001);
      chk("rerun_multu_lo", {32'd0, lo}, 64'hFFFFFFFE);
      tick();

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
